// File: rtl/ff_pkg.sv
// Shared definitions for the multi-mode register bank: operation-select encoding.
package ff_pkg;

    // Operation select presented on the 3-bit mode input.
    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_JK   = 3'b010,
        MODE_TOG  = 3'b011,
        MODE_SHL  = 3'b100,
        MODE_SHR  = 3'b101,
        MODE_INC  = 3'b110,
        MODE_DEC  = 3'b111
    } ff_mode_e;

    localparam int MODE_W = 3;

endpackage

// File: rtl/ff_next_state.sv
// Combinational next-state logic for ff_reg_bank: computes the candidate state,
// the wrap carry and the serial bit shifted out, assuming the operation is enabled.
module ff_next_state
    import ff_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  state,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  D,
    input  logic [WIDTH-1:0]  J,
    input  logic [WIDTH-1:0]  K,
    input  logic [WIDTH-1:0]  T,
    input  logic              ser_in,
    output logic [WIDTH-1:0]  state_nxt,
    output logic              carry_nxt,
    output logic              ser_load,
    output logic              ser_bit
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Decode the selected operation into next-state, carry and serial-out values.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
        state_nxt = state;
        carry_nxt = 1'b0;
        ser_load  = 1'b0;
        ser_bit   = 1'b0;
        case (ff_mode_e'(mode))
            MODE_HOLD: state_nxt = state;
            MODE_LOAD: state_nxt = D;
            // JK characteristic: set where J, keep where not K, toggles when both.
            MODE_JK:   state_nxt = (J & ~state) | (~K & state);
            MODE_TOG:  state_nxt = state ^ T;
            MODE_SHL: begin
                state_nxt = {state[WIDTH-2:0], ser_in};
                ser_load  = 1'b1;
                ser_bit   = state[WIDTH-1];
            end
            MODE_SHR: begin
                state_nxt = {ser_in, state[WIDTH-1:1]};
                ser_load  = 1'b1;
                ser_bit   = state[0];
            end
            MODE_INC: begin
                state_nxt = state + ONE;
                carry_nxt = &state;
            end
            MODE_DEC: begin
                state_nxt = state - ONE;
                carry_nxt = ~|state;
            end
            default: state_nxt = state;
        endcase
    end

endmodule

// File: rtl/ff_reg_bank.sv
// WIDTH-bit multi-mode register bank (D / JK / T / shift / count) with true and
// complemented registered outputs, serial-out, wrap carry and change pulse.
// Optional synchronous clear input sclr is present when FF_SYNC_CLR_EN is defined.
module ff_reg_bank
    import ff_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  D,
    input  logic [WIDTH-1:0]  J,
    input  logic [WIDTH-1:0]  K,
    input  logic [WIDTH-1:0]  T,
    input  logic              ser_in,
`ifdef FF_SYNC_CLR_EN
    input  logic              sclr,
`endif
    output logic [WIDTH-1:0]  state,
    output logic [WIDTH-1:0]  reState,
    output logic              ser_out,
    output logic              carry,
    output logic              changed
);

    logic [WIDTH-1:0] state_nxt;
    logic             carry_nxt;
    logic             ser_load;
    logic             ser_bit;
    logic             clr;

    logic [WIDTH-1:0] state_d;
    logic             carry_d;
    logic             ser_d;

`ifdef FF_SYNC_CLR_EN
    assign clr = sclr;
`else
    assign clr = 1'b0;
`endif

    ff_next_state #(
        .WIDTH (WIDTH)
    ) u_next (
        .state     (state),
        .mode      (mode),
        .D         (D),
        .J         (J),
        .K         (K),
        .T         (T),
        .ser_in    (ser_in),
        .state_nxt (state_nxt),
        .carry_nxt (carry_nxt),
        .ser_load  (ser_load),
        .ser_bit   (ser_bit)
    );

    // Select what the registers load: clear beats enable, enable beats hold.
    always_comb begin
        state_d = state;
        carry_d = 1'b0;
        ser_d   = ser_out;
        if (clr) begin
            state_d = RST_VAL;
            ser_d   = 1'b0;
        end else if (en) begin
            state_d = state_nxt;
            carry_d = carry_nxt;
            if (ser_load) begin
                ser_d = ser_bit;
            end
        end
    end

    // Output registers; reState is its own flop so it never glitches against state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RST_VAL;
            reState <= ~RST_VAL;
            ser_out <= 1'b0;
            carry   <= 1'b0;
            changed <= 1'b0;
        end else begin
            // NOTE: non-blocking so changed compares against the pre-edge state value.
            state   <= state_d;
            reState <= ~state_d;
            ser_out <= ser_d;
            carry   <= carry_d;
            changed <= (state_d != state);
        end
    end

endmodule

// File: tb/tb_ff_reg_bank.sv
// Self-checking bench for ff_reg_bank (WIDTH=8, RST_VAL=8'h5A): directed scenarios
// plus randomized operations checked against an arithmetic reference model.
module tb_ff_reg_bank;

    localparam logic [7:0] RV = 8'h5A;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] D = 8'h00, J = 8'h00, K = 8'h00, T = 8'h00;
    logic       ser_in = 1'b0;
    logic       sclr = 1'b0;
    logic [7:0] state, reState;
    logic       ser_out, carry, changed;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [7:0] m_state = RV;
    logic       m_ser = 1'b0, m_carry = 1'b0, m_changed = 1'b0;

    ff_reg_bank #(.WIDTH(8), .RST_VAL(RV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .D       (D),
        .J       (J),
        .K       (K),
        .T       (T),
        .ser_in  (ser_in),
`ifdef FF_SYNC_CLR_EN
        .sclr    (sclr),
`endif
        .state   (state),
        .reState (reState),
        .ser_out (ser_out),
        .carry   (carry),
        .changed (changed)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = RV; m_ser = 1'b0; m_carry = 1'b0; m_changed = 1'b0;
    endtask

    // Apply the behaviour rules for one clock edge using plain integer arithmetic.
    task automatic model_edge(input bit e, input int md, input int d, input int j,
                              input int k, input int t, input bit si, input bit sc);
        int s, ns;
        s = int'(m_state);
        ns = s;
        m_carry = 1'b0;
        if (sc) begin
            ns = int'(RV);
            m_ser = 1'b0;
        end else if (e) begin
            case (md)
                0: ns = s;
                1: ns = d;
                2: begin
                    ns = 0;
                    for (int b = 0; b < 8; b++) begin
                        int jb, kb, ob, nb;
                        jb = (j >> b) & 1; kb = (k >> b) & 1; ob = (s >> b) & 1;
                        if (jb == 1 && kb == 1) nb = 1 - ob;
                        else if (jb == 1)       nb = 1;
                        else if (kb == 1)       nb = 0;
                        else                    nb = ob;
                        ns = ns + (nb << b);
                    end
                end
                3: ns = s ^ t;
                4: begin ns = (s * 2 + int'(si)) % 256; m_ser = (s / 128) != 0; end
                5: begin ns = s / 2 + int'(si) * 128;   m_ser = (s % 2) != 0;   end
                6: begin ns = (s + 1) % 256;   m_carry = (s == 255); end
                default: begin ns = (s + 255) % 256; m_carry = (s == 0); end
            endcase
        end
        m_changed = (ns != s);
        m_state = 8'(ns);
    endtask

    // Drive one operation, let it be sampled on the next edge, then advance the model.
    task automatic cycle(input bit e, input logic [2:0] md, input logic [7:0] d,
                         input logic [7:0] j, input logic [7:0] k, input logic [7:0] t,
                         input bit si, input bit sc);
        en = e; mode = md; D = d; J = j; K = k; T = t; ser_in = si; sclr = sc;
        @(posedge clk);
        #1;
        model_edge(e, int'(md), int'(d), int'(j), int'(k), int'(t), si, sc);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (state !== RV || reState !== ~RV) begin
            errors++;
            $display("FAIL reset_init: state=%h reState=%h, expected %h %h", state, reState, RV, ~RV);
        end
        checks++;
        if ({ser_out, carry, changed} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: ser_out/carry/changed=%b, expected 000", {ser_out, carry, changed});
        end
        #5 rst_n = 1'b1;
        model_reset();
        // First edge after release with HOLD: nothing moves.
        cycle(1, 3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        checks++;
        if (state !== RV || changed !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: state=%h changed=%b, expected %h 0", state, changed, RV);
        end
        // Count up, then assert reset between edges while still counting.
        repeat (3) cycle(1, 3'b110, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        checks++;
        if (state !== 8'h5D) begin
            errors++;
            $display("FAIL reset_pre_inc: state=%h, expected 5d", state);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 8'h5A || reState !== 8'hA5) begin
            errors++;
            $display("FAIL reset_async: state=%h reState=%h, expected 5a a5", state, reState);
        end
        checks++;
        if ({ser_out, carry, changed} !== 3'b000) begin
            errors++;
            $display("FAIL reset_async_flags: ser_out/carry/changed=%b, expected 000", {ser_out, carry, changed});
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_jk();
        cycle(1, 3'b001, 8'h0F, 8'h00, 8'h00, 8'h00, 0, 0);
        cycle(1, 3'b010, 8'h00, 8'hF0, 8'h3C, 8'h00, 0, 0);
        checks++;
        if (state !== 8'hF3 || reState !== 8'h0C || changed !== 1'b1) begin
            errors++;
            $display("FAIL jk: state=%h reState=%h changed=%b, expected f3 0c 1", state, reState, changed);
        end
    endtask

    task automatic test_inc_wrap();
        cycle(1, 3'b001, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0);
        cycle(1, 3'b110, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        checks++;
        if (state !== 8'h00 || carry !== 1'b1) begin
            errors++;
            $display("FAIL inc_wrap: state=%h carry=%b, expected 00 1", state, carry);
        end
        cycle(1, 3'b110, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        checks++;
        if (state !== 8'h01 || carry !== 1'b0) begin
            errors++;
            $display("FAIL inc_after_wrap: state=%h carry=%b, expected 01 0", state, carry);
        end
    endtask

    task automatic test_dec_wrap();
        cycle(1, 3'b001, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        cycle(1, 3'b111, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        checks++;
        if (state !== 8'hFF || carry !== 1'b1 || reState !== 8'h00) begin
            errors++;
            $display("FAIL dec_wrap: state=%h carry=%b reState=%h, expected ff 1 00", state, carry, reState);
        end
    endtask

    task automatic test_shift();
        cycle(1, 3'b001, 8'h81, 8'h00, 8'h00, 8'h00, 0, 0);
        cycle(1, 3'b100, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        checks++;
        if (state !== 8'h02 || ser_out !== 1'b1) begin
            errors++;
            $display("FAIL shl: state=%h ser_out=%b, expected 02 1", state, ser_out);
        end
        cycle(1, 3'b101, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        checks++;
        if (state !== 8'h01 || ser_out !== 1'b0) begin
            errors++;
            $display("FAIL shr: state=%h ser_out=%b, expected 01 0", state, ser_out);
        end
        // ser_out holds through a non-shift op.
        cycle(1, 3'b100, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0);
        cycle(1, 3'b001, 8'h80, 8'h00, 8'h00, 8'h00, 0, 0);
        checks++;
        if (state !== 8'h80 || ser_out !== 1'b0) begin
            errors++;
            $display("FAIL ser_hold: state=%h ser_out=%b, expected 80 0", state, ser_out);
        end
    endtask

    task automatic test_enable();
        cycle(1, 3'b001, 8'h21, 8'h00, 8'h00, 8'h00, 0, 0);
        cycle(0, 3'b001, 8'h33, 8'h00, 8'h00, 8'h00, 0, 0);
        checks++;
        if (state !== 8'h21 || changed !== 1'b0 || carry !== 1'b0) begin
            errors++;
            $display("FAIL en_low: state=%h changed=%b carry=%b, expected 21 0 0", state, changed, carry);
        end
        cycle(1, 3'b001, 8'h21, 8'h00, 8'h00, 8'h00, 0, 0);
        checks++;
        if (changed !== 1'b0) begin
            errors++;
            $display("FAIL load_same: changed=%b, expected 0", changed);
        end
        cycle(1, 3'b011, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        checks++;
        if (state !== 8'h21 || changed !== 1'b0) begin
            errors++;
            $display("FAIL tog_zero: state=%h changed=%b, expected 21 0", state, changed);
        end
`ifdef FF_SYNC_CLR_EN
        cycle(1, 3'b001, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0);
        cycle(1, 3'b110, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1);
        checks++;
        if (state !== RV || reState !== ~RV || carry !== 1'b0 || changed !== 1'b1) begin
            errors++;
            $display("FAIL sclr: state=%h reState=%h carry=%b changed=%b, expected %h %h 0 1",
                     state, reState, carry, changed, RV, ~RV);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit e, sc;
            e  = ($urandom_range(0, 7) != 0);
            sc = 1'b0;
`ifdef FF_SYNC_CLR_EN
            sc = ($urandom_range(0, 15) == 0);
`endif
            cycle(e, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom_range(0, 3) == 0 ? 0 : $urandom), 1'($urandom), sc);
            checks++;
            if (state !== m_state || reState !== ~m_state || ser_out !== m_ser ||
                carry !== m_carry || changed !== m_changed) begin
                errors++;
                $display("FAIL random[%0d]: state=%h reState=%h ser_out=%b carry=%b changed=%b, expected %h %h %b %b %b",
                         i, state, reState, ser_out, carry, changed,
                         m_state, ~m_state, m_ser, m_carry, m_changed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_jk();
        test_inc_wrap();
        test_dec_wrap();
        test_shift();
        test_enable();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
